// File: rtl/hilo_commit_unit.sv
// HI/LO commit unit for an N-issue MIPS pre-memory stage: collects mul/div
// results, forwards intra-bundle HI/LO to later lanes, commits once per bundle.
module hilo_commit_unit #(
  parameter int LANES = 2,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pms_valid,
  input  logic               ms_allowin,
  input  logic               flush,
  input  logic [LANES-1:0]   lane_valid,
  input  logic [LANES-1:0]   lane_hi_we,
  input  logic [LANES-1:0]   lane_lo_we,
  input  logic [2*LANES-1:0] lane_src,
  input  logic [W*LANES-1:0] lane_rs_value,
  input  logic [LANES-1:0]   lane_except,
  input  logic [LANES-1:0]   lane_eret,
  input  logic               mul_res_valid,
  input  logic [2*W-1:0]     mul_res,
  input  logic               div_res_valid,
  input  logic [2*W-1:0]     div_res,
  output logic               hilo_ready_go,
  output logic [W*LANES-1:0] rd_hi,
  output logic [W*LANES-1:0] rd_lo,
  output logic [W-1:0]       mul_lo,
  output logic [W-1:0]       hi,
  output logic [W-1:0]       lo
);

  localparam logic [1:0] SRC_RS  = 2'b00;
  localparam logic [1:0] SRC_MUL = 2'b01;
  localparam logic [1:0] SRC_DIV = 2'b10;

  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0] mul_hold_q, mul_hold_d, div_hold_q, div_hold_d;
  logic           mul_have_q, mul_have_d, div_have_q, div_have_d;

  logic [2*W-1:0] mul_eff, div_eff;
  logic [LANES-1:0] live, hi_wen, lo_wen;
  logic [W-1:0]   wr_hi [LANES];
  logic [W-1:0]   wr_lo [LANES];
  logic           need_mul, need_div, killed;
  logic [W-1:0]   run_hi, run_lo;
  logic           fire;

  assign mul_eff = mul_have_q ? mul_hold_q : mul_res;
  assign div_eff = div_have_q ? div_hold_q : div_res;
  assign mul_lo  = mul_eff[W-1:0];
  assign hi      = hi_q;
  assign lo      = lo_q;

  // Lanes from the first excepting/ERET lane onward are squashed; the walk
  // also builds the running HI/LO each lane observes from older lanes only.
  always_comb begin
    live     = '0;
    hi_wen   = '0;
    lo_wen   = '0;
    need_mul = 1'b0;
    need_div = 1'b0;
    killed   = 1'b0;
    run_hi   = hi_q;
    run_lo   = lo_q;
    rd_hi    = '0;
    rd_lo    = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_hi[k] = lane_rs_value[k*W +: W];
      wr_lo[k] = lane_rs_value[k*W +: W];
      if (lane_valid[k] && (lane_except[k] || lane_eret[k])) killed = 1'b1;
      live[k] = lane_valid[k] && !killed;
      case (lane_src[2*k +: 2])
        SRC_MUL: begin
          wr_hi[k] = mul_eff[2*W-1:W];
          wr_lo[k] = mul_eff[W-1:0];
          need_mul = need_mul || live[k];
        end
        SRC_DIV: begin
          wr_hi[k] = div_eff[W-1:0];
          wr_lo[k] = div_eff[2*W-1:W];
          need_div = need_div || live[k];
        end
        default: ;
      endcase
      hi_wen[k] = live[k] && lane_hi_we[k] && (lane_src[2*k +: 2] != 2'b11);
      lo_wen[k] = live[k] && lane_lo_we[k] && (lane_src[2*k +: 2] != 2'b11);
      rd_hi[k*W +: W] = run_hi;
      rd_lo[k*W +: W] = run_lo;
      if (hi_wen[k]) run_hi = wr_hi[k];
      if (lo_wen[k]) run_lo = wr_lo[k];
    end
  end

  assign hilo_ready_go = !pms_valid ||
                         !((need_mul && !(mul_have_q || mul_res_valid)) ||
                           (need_div && !(div_have_q || div_res_valid)));

  // Handshake: the bundle leaves (fires) in a cycle where pms_valid, hilo_ready_go
  // and ms_allowin are all high and flush is low; otherwise it is held in place.
  assign fire = pms_valid && hilo_ready_go && ms_allowin && !flush;

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    mul_hold_d = mul_hold_q;
    div_hold_d = div_hold_q;
    mul_have_d = mul_have_q;
    div_have_d = div_have_q;
    if (flush) begin
      mul_have_d = 1'b0;
      div_have_d = 1'b0;
    end else if (fire) begin
      hi_d       = run_hi;
      lo_d       = run_lo;
      mul_have_d = 1'b0;
      div_have_d = 1'b0;
    end else begin
      if (mul_res_valid && pms_valid && !mul_have_q) begin
        mul_hold_d = mul_res;
        mul_have_d = 1'b1;
      end
      if (div_res_valid && pms_valid && !div_have_q) begin
        div_hold_d = div_res;
        div_have_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      mul_hold_q <= '0;
      div_hold_q <= '0;
      mul_have_q <= 1'b0;
      div_have_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mul_hold_q <= mul_hold_d;
      div_hold_q <= div_hold_d;
      mul_have_q <= mul_have_d;
      div_have_q <= div_have_d;
    end
  end

endmodule
